// File: rtl/rf_mp_if.sv
// Bus bundle for the rf_mp register file: write, read and scoreboard-set ports.
// The testbench drives through the master modport; rf_mp uses the slave modport.
interface rf_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [1:0]          wr_en_i;
    logic [2*AW-1:0]     wr_addr_i;
    logic [2*XLEN-1:0]   wr_data_i;
    logic [NRD-1:0]      rd_en_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                sb_set_i;
    logic [AW-1:0]       sb_addr_i;
    logic [NREGS-1:0]    busy_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i, sb_set_i, sb_addr_i,
        input  rd_data_o, rd_busy_o, busy_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i, sb_set_i, sb_addr_i,
        output rd_data_o, rd_busy_o, busy_o
    );
endinterface

// File: rtl/rf_mp.sv
// Two-write, NRD-read register file with a per-register pending (busy) scoreboard.
// Define RF_MP_BYPASS_EN to forward same-cycle write data to reads of that register.
module rf_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input logic   clk_i,
    input logic   rst_i,
    rf_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs    [NREGS];
    logic [XLEN-1:0]     regs_nx [NREGS];
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    busy_nx;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD*XLEN-1:0] rd_data_nx;
    logic [NRD-1:0]      rd_busy;
    logic [NRD-1:0]      rd_busy_nx;
    logic [AW-1:0]       wa;
    logic [AW-1:0]       ra;

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // the scoreboard set is applied after the clears so set beats clear.
    always_comb begin
        regs_nx    = regs;
        busy_nx    = busy;
        rd_data_nx = '0;
        rd_busy_nx = '0;
        wa         = '0;
        ra         = '0;
        for (int k = 0; k < 2; k++) begin
            wa = bus.wr_addr_i[k*AW +: AW];
            if (bus.wr_en_i[k] && wa != '0) begin
                regs_nx[wa] = bus.wr_data_i[k*XLEN +: XLEN];
                busy_nx[wa] = 1'b0;
            end
        end
        if (bus.sb_set_i && bus.sb_addr_i != '0)
            busy_nx[bus.sb_addr_i] = 1'b1;
        busy_nx[0] = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            ra = bus.rd_addr_i[p*AW +: AW];
            if (ra != '0) begin
`ifdef RF_MP_BYPASS_EN
                rd_data_nx[p*XLEN +: XLEN] = regs_nx[ra];
`else
                rd_data_nx[p*XLEN +: XLEN] = regs[ra];
`endif
            end
            rd_busy_nx[p] = busy_nx[ra];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            busy    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            regs <= regs_nx;
            busy <= busy_nx;
            for (int p = 0; p < NRD; p++) begin
                if (bus.rd_en_i[p]) begin
                    rd_data[p*XLEN +: XLEN] <= rd_data_nx[p*XLEN +: XLEN];
                    rd_busy[p]              <= rd_busy_nx[p];
                end
            end
        end
    end

    assign bus.rd_data_o = rd_data;
    assign bus.rd_busy_o = rd_busy;
    assign bus.busy_o    = busy;
endmodule

// File: doc/rf_mp.md
RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width per register.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the register count; it SHALL be a power of two and at least 2; AW = log2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 2, meaning the read port count, valid range 1-4.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk_i: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port rst_i: input, 1 bit, synchronous active-high reset.
REQ-007 Port wr_en_i: input, 2 bits, write enable per write port (bit k = port k).
REQ-008 Port wr_addr_i: input, 2*AW bits, write address, port k at slice [k*AW +: AW].
REQ-009 Port wr_data_i: input, 2*XLEN bits, write data, port k at slice [k*XLEN +: XLEN].
REQ-010 Port rd_en_i: input, NRD bits, read enable per read port.
REQ-011 Port rd_addr_i: input, NRD*AW bits, read address per port, packed as for writes.
REQ-012 Port rd_data_o: output, NRD*XLEN bits, registered read data per port.
REQ-013 Port rd_busy_o: output, NRD bits, registered scoreboard bit of the address read on each port.
REQ-014 Port sb_set_i: input, 1 bit, marks register sb_addr_i as pending.
REQ-015 Port sb_addr_i: input, AW bits, scoreboard set address.
REQ-016 Port busy_o: output, NREGS bits, live scoreboard bitmap; bit 0 is constant 0.

Function
REQ-017 Register 0 SHALL always read as zero; writes to it SHALL be ignored, and it SHALL never be marked busy.
REQ-018 Each write port SHALL update its addressed register at the rising edge when its enable is high.
REQ-019 When both write ports target the same nonzero address in one cycle, port 1 SHALL win.
REQ-020 Reads SHALL have 1-cycle latency: at the edge where rd_en_i[p] is high, rd_data_o[p] and rd_busy_o[p] SHALL load the data and busy bit for rd_addr_i[p].
REQ-021 When rd_en_i[p] is low, rd_data_o[p] and rd_busy_o[p] SHALL hold their values.
REQ-022 Any number of read ports SHALL be able to read the same address in one cycle.
REQ-023 The busy bit of register r SHALL clear at an edge where any write port writes r.
REQ-024 The busy bit of register r SHALL set at an edge where sb_set_i is high with sb_addr_i = r, provided r is nonzero.
REQ-025 When a set and a clear of the same register coincide, the set SHALL win and the bit SHALL end at 1.
REQ-026 The rd_busy_o value SHALL reflect the busy bit after that edge's clear and set, so that it matches busy_o in the following cycle.
REQ-027 All other registers and busy bits SHALL be unaffected by an access.

Reset
REQ-028 While rst_i is high at an edge, all registers SHALL become 0, busy_o SHALL become all-zero, and rd_data_o and rd_busy_o SHALL become 0.
REQ-029 Reset SHALL take priority over coincident writes, reads and scoreboard sets, and those requests SHALL be dropped.
REQ-030 The first edge with rst_i low SHALL process requests normally.

Configuration
REQ-031 When macro RF_MP_BYPASS_EN is defined, a read of a nonzero address written in the same cycle SHALL return the new write data, using the port 1 value if both write ports target it.
REQ-032 When RF_MP_BYPASS_EN is undefined, such a read SHALL return the pre-write register value.
REQ-033 The macro SHALL NOT change the behaviour of busy bits or register 0.

Verification
REQ-034 Reset check: after reset, a read of x5 on port 0 SHALL return 0 and busy_o SHALL be 0.
REQ-035 Dual-write priority check: write 0x11 to x3 on port 0 and 0x22 to x3 on port 1 in the same cycle; a read of x3 next cycle SHALL return 0x22.
REQ-036 Bypass check: write 0xDEADBEEF to x7 while reading x7 in the same cycle; the read SHALL return 0xDEADBEEF with the macro defined and the old value 0 without it.
REQ-037 Register 0 check: write 0xFFFFFFFF to x0 and read x0 on all ports; every port SHALL return 0 in every build.
REQ-038 Scoreboard check: set x9, then write x9 while setting x9 again in the same cycle; busy_o[9] SHALL stay 1, and a later write with no set SHALL clear it to 0.
REQ-039 Mid-operation reset check: assert rst_i together with a write of 0x55 to x4 and a set of x4; x4 SHALL read 0 and busy_o[4] SHALL be 0.
